// File: rtl/pong_score_keeper.sv
// Pong referee: samples ball/paddle positions once per frame, detects hits and
// misses, keeps both scores, and raises a held loss level until gmv drops.
module pong_score_keeper #(
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int LEFT_X    = 16,
  parameter int RIGHT_X   = 616,
  parameter int PADDLE_H  = 64,
  parameter int BALL_SZ   = 8,
  parameter int SW        = 4,
  parameter int WIN_SCORE = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gmv,
  input  logic          frame_tick,
  input  logic [XW-1:0] ball_x,
  input  logic [YW-1:0] ball_y,
  input  logic [YW-1:0] paddleA_y,
  input  logic [YW-1:0] paddleB_y,
  output logic          lossA,
  output logic          lossB,
  output logic          hitA,
  output logic          hitB,
  output logic [SW-1:0] scoreA,
  output logic [SW-1:0] scoreB,
  output logic          game_over,
  output logic          winner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    LOSS_A = 3'd2,
    LOSS_B = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [SW-1:0] WIN_Q = SW'(WIN_SCORE);
  localparam logic [SW-1:0] ONE_Q = SW'(1);

  state_t        state_q, state_d;
  logic          lossA_q, lossA_d;
  logic          lossB_q, lossB_d;
  logic          hitA_q, hitA_d;
  logic          hitB_q, hitB_d;
  logic [SW-1:0] scoreA_q, scoreA_d;
  logic [SW-1:0] scoreB_q, scoreB_d;
  logic          game_over_q, game_over_d;
  logic          winner_q, winner_d;

  logic at_a_edge, at_b_edge, a_overlap, b_overlap;

  // One extra bit keeps ball_y+BALL_SZ and paddle_y+PADDLE_H from wrapping.
  function automatic logic overlap(input logic [YW-1:0] by, input logic [YW-1:0] py);
    logic [YW:0] b_ext;
    logic [YW:0] p_ext;
    b_ext = {1'b0, by};
    p_ext = {1'b0, py};
    return ((b_ext + (YW+1)'(BALL_SZ)) > p_ext) && (b_ext < (p_ext + (YW+1)'(PADDLE_H)));
  endfunction

  assign at_a_edge = (ball_x <= XW'(LEFT_X));
  assign at_b_edge = (ball_x >= XW'(RIGHT_X));
  assign a_overlap = overlap(ball_y, paddleA_y);
  assign b_overlap = overlap(ball_y, paddleB_y);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    lossA_d     = lossA_q;
    lossB_d     = lossB_q;
    hitA_d      = 1'b0;
    hitB_d      = 1'b0;
    scoreA_d    = scoreA_q;
    scoreB_d    = scoreB_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    case (state_q)
      IDLE: begin
        if (gmv) begin
          state_d = PLAY;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (!gmv) begin
          state_d = IDLE;
        end else if (frame_tick && at_a_edge) begin
          // A side wins ties when both edge conditions hold.
          if (a_overlap) begin
            hitA_d = 1'b1;
          end else begin
            lossA_d  = 1'b1;
            scoreB_d = scoreB_q + ONE_Q;
            state_d  = LOSS_A;
          end
        end else if (frame_tick && at_b_edge) begin
          if (b_overlap) begin
            hitB_d = 1'b1;
          end else begin
            lossB_d  = 1'b1;
            scoreA_d = scoreA_q + ONE_Q;
            state_d  = LOSS_B;
          end
        end else begin
          state_d = PLAY;
        end
      end
      LOSS_A: begin
        if (!gmv) begin
          lossA_d = 1'b0;
          if (scoreB_q == WIN_Q) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lossA_d = 1'b1;
        end
      end
      LOSS_B: begin
        if (!gmv) begin
          lossB_d = 1'b0;
          if (scoreA_q == WIN_Q) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lossB_d = 1'b1;
        end
      end
      OVER: begin
        state_d     = OVER;
        lossA_d     = 1'b0;
        lossB_d     = 1'b0;
        game_over_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        lossA_d     = 1'b0;
        lossB_d     = 1'b0;
        game_over_d = 1'b0;
        winner_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lossA_q     <= 1'b0;
      lossB_q     <= 1'b0;
      hitA_q      <= 1'b0;
      hitB_q      <= 1'b0;
      scoreA_q    <= '0;
      scoreB_q    <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lossA_q     <= lossA_d;
      lossB_q     <= lossB_d;
      hitA_q      <= hitA_d;
      hitB_q      <= hitB_d;
      scoreA_q    <= scoreA_d;
      scoreB_q    <= scoreB_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign lossA     = lossA_q;
  assign lossB     = lossB_q;
  assign hitA      = hitA_q;
  assign hitB      = hitB_q;
  assign scoreA    = scoreA_q;
  assign scoreB    = scoreB_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed plus randomized bench for pong_score_keeper, checked every cycle
// against a rule-level reference model of the referee.
module tb_pong_score_keeper;
  localparam int XW = 10, YW = 10, LEFT_X = 16, RIGHT_X = 616;
  localparam int PADDLE_H = 64, BALL_SZ = 8, SW = 4, WIN_SCORE = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          gmv = 1'b0;
  logic          frame_tick = 1'b0;
  logic [XW-1:0] ball_x = '0;
  logic [YW-1:0] ball_y = '0;
  logic [YW-1:0] paddleA_y = '0;
  logic [YW-1:0] paddleB_y = '0;
  logic          lossA, lossB, hitA, hitB, game_over, winner;
  logic [SW-1:0] scoreA, scoreB;

  int checks = 0;
  int errors = 0;

  // Reference model: expected outputs plus whether a rally is running.
  bit e_lossA, e_lossB, e_hitA, e_hitB, e_over, e_winner, e_play;
  int e_scoreA, e_scoreB;

  pong_score_keeper #(
    .XW(XW), .YW(YW), .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X), .PADDLE_H(PADDLE_H),
    .BALL_SZ(BALL_SZ), .SW(SW), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk), .rst(rst), .gmv(gmv), .frame_tick(frame_tick),
    .ball_x(ball_x), .ball_y(ball_y), .paddleA_y(paddleA_y), .paddleB_y(paddleB_y),
    .lossA(lossA), .lossB(lossB), .hitA(hitA), .hitB(hitB),
    .scoreA(scoreA), .scoreB(scoreB), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic bit ovl(input int by, input int py);
    return (by + BALL_SZ > py) && (by < py + PADDLE_H);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lossA"}, 32'(lossA), 32'(e_lossA));
    chk({tag, ".lossB"}, 32'(lossB), 32'(e_lossB));
    chk({tag, ".hitA"}, 32'(hitA), 32'(e_hitA));
    chk({tag, ".hitB"}, 32'(hitB), 32'(e_hitB));
    chk({tag, ".scoreA"}, 32'(scoreA), 32'(e_scoreA));
    chk({tag, ".scoreB"}, 32'(scoreB), 32'(e_scoreB));
    chk({tag, ".game_over"}, 32'(game_over), 32'(e_over));
    if (e_over) chk({tag, ".winner"}, 32'(winner), 32'(e_winner));
  endtask

  task automatic model_reset();
    e_lossA = 0; e_lossB = 0; e_hitA = 0; e_hitB = 0;
    e_over = 0; e_winner = 0; e_play = 0; e_scoreA = 0; e_scoreB = 0;
  endtask

  // Applies the referee rules to the inputs present at the coming clock edge.
  task automatic model_step();
    e_hitA = 0;
    e_hitB = 0;
    if (e_over) begin
    end else if (e_lossA) begin
      if (!gmv) begin
        e_lossA = 0;
        if (e_scoreB == WIN_SCORE) begin e_over = 1; e_winner = 1; end
      end
    end else if (e_lossB) begin
      if (!gmv) begin
        e_lossB = 0;
        if (e_scoreA == WIN_SCORE) begin e_over = 1; e_winner = 0; end
      end
    end else if (!e_play) begin
      e_play = gmv;
    end else if (!gmv) begin
      e_play = 0;
    end else if (frame_tick) begin
      if (int'(ball_x) <= LEFT_X) begin
        if (ovl(int'(ball_y), int'(paddleA_y))) e_hitA = 1;
        else begin e_lossA = 1; e_scoreB++; e_play = 0; end
      end else if (int'(ball_x) >= RIGHT_X) begin
        if (ovl(int'(ball_y), int'(paddleB_y))) e_hitB = 1;
        else begin e_lossB = 1; e_scoreA++; e_play = 0; end
      end
    end
  endtask

  task automatic drive(input bit g, input bit t, input int bx, input int by, input int pa, input int pb);
    gmv = g; frame_tick = t;
    ball_x = XW'(bx); ball_y = YW'(by); paddleA_y = YW'(pa); paddleB_y = YW'(pb);
  endtask

  task automatic cyc(input string tag, input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst.async");
    chk("rst.winner", 32'(winner), 32'd0);
    @(posedge clk);
    #1;
    check_all("rst.held");
    rst = 1'b0;
  endtask

  // One tick at the given position, then acknowledge any miss and re-enter play.
  task automatic shot(input string tag, input int bx, input int by, input int pa, input int pb);
    drive(1, 1, bx, by, pa, pb);
    cyc(tag);
    frame_tick = 1'b0;
    cyc({tag, ".post"});
    if (e_lossA || e_lossB) begin
      gmv = 1'b0;
      cyc({tag, ".ack"});
      gmv = 1'b1;
      cyc({tag, ".rearm"});
    end
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Test 1: simple hit on paddle A
    drive(1, 0, 300, 100, 80, 300);
    cyc("t1.enter");
    drive(1, 1, 10, 100, 80, 300);
    cyc("t1.tick");
    chk("t1.hitA_pulse", 32'(hitA), 32'd1);
    frame_tick = 1'b0;
    cyc("t1.after");
    chk("t1.hitA_drop", 32'(hitA), 32'd0);

    // Test 2: miss on A, loss held across 50 ticks, then acknowledged
    drive(1, 1, 10, 200, 80, 300);
    cyc("t2.miss");
    chk("t2.lossA", 32'(lossA), 32'd1);
    chk("t2.scoreB", 32'(scoreB), 32'd1);
    cyc("t2.hold", 50);
    chk("t2.lossA_held", 32'(lossA), 32'd1);
    drive(0, 0, 300, 200, 80, 300);
    cyc("t2.ack");
    chk("t2.lossA_clr", 32'(lossA), 32'd0);
    drive(1, 1, 10, 200, 80, 300);
    cyc("t2.idle_ignores_tick");
    chk("t2.no_loss_in_idle", 32'(lossA), 32'd0);

    // Test 3: overlap boundaries against paddleA_y=80
    shot("t3.y72", 10, 72, 80, 300);
    shot("t3.y73", 10, 73, 80, 300);
    shot("t3.y143", 10, 143, 80, 300);
    shot("t3.y144", 10, 144, 80, 300);
    chk("t3.scoreB", 32'(scoreB), 32'd3);

    // Test 4: A wins with seven B-side misses
    do_reset();
    drive(1, 0, 300, 500, 0, 100);
    cyc("t4.enter");
    for (int k = 0; k < 7; k++) shot("t4.missB", 620, 500, 0, 100);
    chk("t4.scoreA", 32'(scoreA), 32'd7);
    chk("t4.game_over", 32'(game_over), 32'd1);
    chk("t4.winner", 32'(winner), 32'd0);
    shot("t4.frozenA", 10, 500, 0, 100);
    shot("t4.frozenB", 620, 500, 0, 100);
    chk("t4.scoreB_frozen", 32'(scoreB), 32'd0);
    chk("t4.scoreA_frozen", 32'(scoreA), 32'd7);

    // Test 5: aborted rally, then reset out of LOSS_B
    do_reset();
    drive(1, 0, 300, 500, 0, 100);
    cyc("t5.enter");
    shot("t5.missA", 10, 500, 0, 100);
    gmv = 1'b0;
    cyc("t5.abort");
    chk("t5.scoreB_kept", 32'(scoreB), 32'd1);
    chk("t5.no_loss", 32'(lossA | lossB), 32'd0);
    drive(1, 0, 300, 500, 0, 100);
    cyc("t5.reenter");
    drive(1, 1, 620, 500, 0, 100);
    cyc("t5.missB");
    chk("t5.lossB", 32'(lossB), 32'd1);
    do_reset();

    // Test 6: overlap near the top of the coordinate range
    drive(1, 0, 300, 1000, 0, 1000);
    cyc("t6.enter");
    drive(1, 1, 620, 1000, 0, 1000);
    cyc("t6.y1000");
    chk("t6.hitB_1000", 32'(hitB), 32'd1);
    drive(1, 1, 620, 1020, 0, 1000);
    cyc("t6.y1020");
    chk("t6.hitB_1020", 32'(hitB), 32'd1);
    shot("t6.y992", 620, 992, 0, 1000);
    chk("t6.scoreA", 32'(scoreA), 32'd1);

    // Randomized play against the model
    for (int n = 0; n < 3000; n++) begin
      int bx, pa, pb, by, sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: bx = int'($urandom_range(0, LEFT_X));
        1: bx = int'($urandom_range(RIGHT_X, 1023));
        2: bx = int'($urandom_range(LEFT_X + 1, RIGHT_X - 1));
        default: bx = ($urandom_range(0, 1) != 0) ? LEFT_X + int'($urandom_range(0, 1))
                                                  : RIGHT_X - int'($urandom_range(0, 1));
      endcase
      pa = int'($urandom_range(0, 1023));
      pb = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) != 0)
        by = ((bx <= LEFT_X ? pa : pb) + int'($urandom_range(0, 80)) - BALL_SZ) & 1023;
      else
        by = int'($urandom_range(0, 1023));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, bx, by, pa, pb);
      cyc("rand");
      if ((e_over && $urandom_range(0, 19) == 0) || $urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Game-side referee for Pong; produces the `lossA`/`lossB` indications that the reset/game-valid generator consumes.
- Samples ball and paddle positions once per frame while `gmv` is high. It detects paddle hits and misses, keeps per-player scores and declares a winner.
- Loss is a level handshake: raised on a miss, held until the generator acknowledges by dropping `gmv`.

Parameters:
- XW, 10, ball_x width
- YW, 10, ball_y / paddle_y width
- LEFT_X, 16, x at or below which the ball is at paddle A's plane
- RIGHT_X, 616, x at or above which the ball is at paddle B's plane
- PADDLE_H, 64, paddle height in pixels
- BALL_SZ, 8, ball side in pixels
- SW, 4, score counter width
- WIN_SCORE, 7, score that ends the game (must be < 2^SW)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- gmv  in  1  game valid from the reset generator; high = play running
- frame_tick  in  1  one-cycle pulse per video frame
- ball_x  in  XW  ball left edge
- ball_y  in  YW  ball top edge
- paddleA_y  in  YW  paddle A top edge
- paddleB_y  in  YW  paddle B top edge
- lossA  out  1  player A missed; level, held until acknowledged
- lossB  out  1  player B missed; level, held until acknowledged
- hitA  out  1  one-cycle pulse, ball struck paddle A
- hitB  out  1  one-cycle pulse, ball struck paddle B
- scoreA  out  SW  points won by A
- scoreB  out  SW  points won by B
- game_over  out  1  high once a player reaches WIN_SCORE
- winner  out  1  0 = A won, 1 = B won; valid only while game_over=1

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0.
- Overlap test for paddle P:
  - true when (ball_y + BALL_SZ > P_y) and (ball_y < P_y + PADDLE_H).
  - Evaluated in YW+1 bits; no wrap.
- States: IDLE, PLAY, LOSS_A, LOSS_B, OVER.
- IDLE:
  - -> PLAY on the first cycle with gmv=1.
  - frame_tick is ignored.
- PLAY, evaluated only on a cycle with frame_tick=1:
  - ball_x <= LEFT_X with A overlap: hitA=1 for that cycle; stay in PLAY.
  - ball_x <= LEFT_X without A overlap: next cycle lossA=1, scoreB+1, -> LOSS_A.
  - ball_x >= RIGHT_X with B overlap: hitB=1 for that cycle; stay in PLAY.
  - ball_x >= RIGHT_X without B overlap: next cycle lossB=1, scoreA+1, -> LOSS_B.
  - Both edge conditions true in the same tick: the A side is evaluated, the B side is ignored.
- PLAY with gmv=0: -> IDLE (aborted rally); scores unchanged; no loss raised.
- hitA/hitB:
  - Registered; asserted the cycle after the tick.
  - Never asserted outside PLAY.
- LOSS_A / LOSS_B:
  - Loss level held while gmv=1; frame_tick ignored.
  - On gmv=0: loss cleared next cycle.
  - Then -> OVER if the incremented score == WIN_SCORE, else -> IDLE.
- OVER:
  - game_over=1; winner=1 if scoreB reached WIN_SCORE, else 0.
  - Scores frozen; loss outputs 0; gmv and frame_tick ignored.
  - Left only via rst.
- Scores never exceed WIN_SCORE, so they never wrap.
- Only one of lossA/lossB is ever high; never high in IDLE or OVER.

Test Plan:
1. gmv=1; tick with ball_x=10, ball_y=100, paddleA_y=80 -> hitA pulses one cycle; lossA stays 0; scores 0/0.
2. gmv=1; tick with ball_x=10, ball_y=200, paddleA_y=80 -> lossA=1 next cycle, scoreB=1, held across 50 further ticks; drop gmv -> lossA=0 one cycle later, state IDLE.
3. Edge overlap with paddleA_y=80: ball_y=72 (bottom edge 80) -> loss; ball_y=73 -> hit; ball_y=143 -> hit; ball_y=144 -> loss.
4. Seven B-side misses, each acknowledged by a gmv low/high cycle -> scoreA=7, game_over=1, winner=0; further ticks and misses change nothing.
5. gmv drops during PLAY with no miss -> IDLE, scores unchanged, no loss; assert rst while in LOSS_B -> all outputs 0 immediately.
6. paddleB_y=1000 (near max), ball_y=1000 -> overlap sums computed without overflow; hit is detected correctly.
